io_byte_port: RTL and testbench

- Downstream I/O device endpoint for the 7-step CPU.
- Consumes the control section's I/O bus strobes (IO_clk_e, IO_clk_s, IO_input_or_output, IO_data_or_address) and the 8-bit CPU bus.
- Implements one addressable byte port: an address-select latch, a TX FIFO (CPU OUT Data → external sink) and an RX FIFO (external source → CPU IN Data).
- Everything is synchronous to sys_clk; the I/O strobes are sampled and edge-detected.

---
 rtl/io_byte_port.sv | 139 +++++++++++++
 tb/tb_io_byte_port.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/io_byte_port.sv
// Single addressable byte port on the CPU I/O bus.
// It has an address-select latch, a TX FIFO fed by OUT Data and an RX FIFO drained by IN Data.
module io_byte_port #(
    parameter logic [7:0] DEV_ADDR = 8'h0F,
    parameter int         TX_DEPTH = 4,
    parameter int         RX_DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       io_clk_e,
    input  logic       io_clk_s,
    input  logic       io_input_or_output,
    input  logic       io_data_or_address,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_drive,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       selected,
    output logic       tx_overflow,
    output logic       rx_underflow
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW-1:0] TX_PTR_ONE = 1;
    localparam logic [RX_AW-1:0] RX_PTR_ONE = 1;
    localparam logic [TX_AW:0]   TX_CNT_ONE = 1;
    localparam logic [RX_AW:0]   RX_CNT_ONE = 1;
    localparam logic [TX_AW:0]   TX_CNT_MAX = TX_DEPTH[TX_AW:0];
    localparam logic [RX_AW:0]   RX_CNT_MAX = RX_DEPTH[RX_AW:0];

    logic s_q, e_q, selected_q, pend_pop_q, tx_overflow_q, rx_underflow_q;
    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [TX_AW-1:0] tx_wr_q, tx_rd_q;
    logic [RX_AW-1:0] rx_wr_q, rx_rd_q;
    logic [TX_AW:0]   tx_cnt_q;
    logic [RX_AW:0]   rx_cnt_q;

    logic s_rise, e_rise, e_fall;
    logic out_addr, out_data, in_data_sel;
    logic tx_full, tx_push, tx_pop, rx_nonempty, rx_push, rx_pop;

    assign s_rise = io_clk_s & ~s_q;
    assign e_rise = io_clk_e & ~e_q;
    assign e_fall = ~io_clk_e & e_q;

    assign out_addr    = s_rise & io_input_or_output & io_data_or_address;
    assign out_data    = s_rise & io_input_or_output & ~io_data_or_address & selected_q;
    assign in_data_sel = e_rise & ~io_input_or_output & ~io_data_or_address & selected_q;

    assign tx_full     = (tx_cnt_q == TX_CNT_MAX);
    assign tx_valid    = (tx_cnt_q != '0);
    assign tx_pop      = tx_valid & tx_ready;
    // A simultaneous pop frees a slot, so a full FIFO can still take the write.
    assign tx_push     = out_data & (~tx_full | tx_pop);
    assign tx_data     = tx_mem_q[tx_rd_q];

    assign rx_nonempty = (rx_cnt_q != '0);
    assign rx_ready    = (rx_cnt_q != RX_CNT_MAX);
    assign rx_push     = rx_valid & rx_ready;
    assign rx_pop      = e_fall & pend_pop_q;

    assign selected     = selected_q;
    assign tx_overflow  = tx_overflow_q;
    assign rx_underflow = rx_underflow_q;

    assign bus_drive = ~reset & io_clk_e & ~io_input_or_output & selected_q;

    always_comb begin
        bus_out = 8'h00;
        if (bus_drive) begin
            if (io_data_or_address)
                bus_out = {6'b0, tx_full, rx_nonempty};
            else if (rx_nonempty)
                bus_out = rx_mem_q[rx_rd_q];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (tx_push)
            tx_mem_q[tx_wr_q] <= bus_in;
        if (rx_push)
            rx_mem_q[rx_wr_q] <= rx_data;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            s_q            <= 1'b0;
            e_q            <= 1'b0;
            selected_q     <= 1'b0;
            pend_pop_q     <= 1'b0;
            tx_overflow_q  <= 1'b0;
            rx_underflow_q <= 1'b0;
            tx_wr_q        <= '0;
            tx_rd_q        <= '0;
            tx_cnt_q       <= '0;
            rx_wr_q        <= '0;
            rx_rd_q        <= '0;
            rx_cnt_q       <= '0;
        end else begin
            s_q <= io_clk_s;
            e_q <= io_clk_e;
            if (out_addr)
                selected_q <= (bus_in == DEV_ADDR);
            if (out_data & tx_full & ~tx_pop)
                tx_overflow_q <= 1'b1;
            if (tx_push)
                tx_wr_q <= tx_wr_q + TX_PTR_ONE;
            if (tx_pop)
                tx_rd_q <= tx_rd_q + TX_PTR_ONE;
            if (tx_push & ~tx_pop)
                tx_cnt_q <= tx_cnt_q + TX_CNT_ONE;
            else if (tx_pop & ~tx_push)
                tx_cnt_q <= tx_cnt_q - TX_CNT_ONE;

            // The RX head is only consumed when the enable strobe ends.
            if (in_data_sel) begin
                pend_pop_q <= rx_nonempty;
                if (!rx_nonempty)
                    rx_underflow_q <= 1'b1;
            end else if (e_fall) begin
                pend_pop_q <= 1'b0;
            end
            if (rx_push)
                rx_wr_q <= rx_wr_q + RX_PTR_ONE;
            if (rx_pop)
                rx_rd_q <= rx_rd_q + RX_PTR_ONE;
            if (rx_push & ~rx_pop)
                rx_cnt_q <= rx_cnt_q + RX_CNT_ONE;
            else if (rx_pop & ~rx_push)
                rx_cnt_q <= rx_cnt_q - RX_CNT_ONE;
        end
    end
endmodule

// File: tb/tb_io_byte_port.sv
// Bench for io_byte_port: directed strobe sequences with queued expectations
// for TX transfers and driven bus values, checked by a negedge monitor.
module tb_io_byte_port;
    logic       sys_clk = 1'b0;
    logic       reset = 1'b1;
    logic       io_clk_e = 1'b0, io_clk_s = 1'b0;
    logic       io_input_or_output = 1'b0, io_data_or_address = 1'b0;
    logic [7:0] bus_in = 8'h00, bus_out, tx_data, rx_data = 8'h00;
    logic       bus_drive, tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready;
    logic       selected, tx_overflow, rx_underflow;

    logic [7:0] tx_exp[$];
    logic [7:0] bus_exp[$];
    int n_checks = 0;
    int n_pass = 0;

    always #5 sys_clk = ~sys_clk;

    io_byte_port #(.DEV_ADDR(8'h0F), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .io_clk_e(io_clk_e), .io_clk_s(io_clk_s),
        .io_input_or_output(io_input_or_output), .io_data_or_address(io_data_or_address),
        .bus_in(bus_in), .bus_out(bus_out), .bus_drive(bus_drive),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .selected(selected), .tx_overflow(tx_overflow), .rx_underflow(rx_underflow)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("check %s: got %02h", name, act);
        end else begin
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: each TX handshake and each driven bus cycle consumes one expectation.
    always @(negedge sys_clk) begin
        if (!reset) begin
            if (tx_valid && tx_ready) begin
                if (tx_exp.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected: got %02h expected none", tx_data);
                end else begin
                    chk("tx_data", tx_data, tx_exp.pop_front());
                end
            end
            if (bus_drive) begin
                if (bus_exp.size() == 0) begin
                    n_checks++;
                    $display("FAIL bus_unexpected: got %02h expected none", bus_out);
                end else begin
                    chk("bus_out", bus_out, bus_exp.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Set strobe held for two cycles to show one action per pulse.
    task automatic s_cycle(input logic ioo, input logic doa, input logic [7:0] val);
        io_input_or_output = ioo;
        io_data_or_address = doa;
        bus_in = val;
        io_clk_s = 1'b1;
        tick();
        tick();
        io_clk_s = 1'b0;
        tick();
    endtask

    task automatic in_read(input logic doa, input int n);
        io_input_or_output = 1'b0;
        io_data_or_address = doa;
        io_clk_e = 1'b1;
        repeat (n) tick();
        io_clk_e = 1'b0;
        tick();
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_data = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic drain_tx();
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && tx_valid; i++) tick();
        @(negedge sys_clk);
        chk("tx_drained_valid", {7'b0, tx_valid}, 8'h00);
        chk("tx_exp_left", 8'(tx_exp.size()), 8'h00);
        tick();
        tx_ready = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        @(negedge sys_clk);
        chk("rst_selected", {7'b0, selected}, 8'h00);
        chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
        chk("rst_flags", {6'b0, tx_overflow, rx_underflow}, 8'h00);
        chk("rst_bus", {bus_drive, bus_out[6:0]}, 8'h00);
        tick();

        // Address decode.
        s_cycle(1, 1, 8'h0F);
        @(negedge sys_clk); chk("sel_match", {7'b0, selected}, 8'h01);
        s_cycle(1, 1, 8'h03);
        @(negedge sys_clk); chk("sel_mismatch", {7'b0, selected}, 8'h00);
        s_cycle(1, 0, 8'hA5);
        @(negedge sys_clk); chk("desel_no_push", {7'b0, tx_valid}, 8'h00);

        // TX fill, overflow, drain.
        s_cycle(1, 1, 8'h0F);
        foreach (tx_exp[i]) ;
        tx_exp.push_back(8'h11); tx_exp.push_back(8'h22);
        tx_exp.push_back(8'h33); tx_exp.push_back(8'h44);
        s_cycle(1, 0, 8'h11); s_cycle(1, 0, 8'h22); s_cycle(1, 0, 8'h33);
        s_cycle(1, 0, 8'h44);
        @(negedge sys_clk); chk("tx_full_no_ovf", {7'b0, tx_overflow}, 8'h00);
        s_cycle(1, 0, 8'h55);
        @(negedge sys_clk);
        chk("tx_valid_full", {7'b0, tx_valid}, 8'h01);
        chk("tx_overflow", {7'b0, tx_overflow}, 8'h01);
        drain_tx();

        // Single pop over a 3-cycle IN Data strobe.
        rx_push(8'h3C);
        repeat (3) bus_exp.push_back(8'h3C);
        in_read(0, 3);
        bus_exp.push_back(8'h00);
        in_read(1, 1);
        @(negedge sys_clk); chk("no_underflow_yet", {7'b0, rx_underflow}, 8'h00);

        // Underflow read, then status byte with TX full and one RX byte.
        bus_exp.push_back(8'h00);
        in_read(0, 1);
        @(negedge sys_clk); chk("rx_underflow", {7'b0, rx_underflow}, 8'h01);
        tick();
        tx_exp.push_back(8'h01); tx_exp.push_back(8'h02);
        tx_exp.push_back(8'h03); tx_exp.push_back(8'h04);
        s_cycle(1, 0, 8'h01); s_cycle(1, 0, 8'h02); s_cycle(1, 0, 8'h03);
        s_cycle(1, 0, 8'h04);
        rx_push(8'h5A);
        bus_exp.push_back(8'h03);
        in_read(1, 1);
        drain_tx();

        // RX full, pop with rx_valid held, order across pointer wrap.
        rx_push(8'hB1); rx_push(8'hB2); rx_push(8'hB3);
        @(negedge sys_clk); chk("rx_full_ready", {7'b0, rx_ready}, 8'h00);
        tick();
        rx_data = 8'hC4;
        rx_valid = 1'b1;
        bus_exp.push_back(8'h5A);
        in_read(0, 1);
        @(negedge sys_clk); chk("rx_ready_after_pop", {7'b0, rx_ready}, 8'h01);
        tick();
        rx_valid = 1'b0;
        @(negedge sys_clk); chk("rx_refilled", {7'b0, rx_ready}, 8'h00);
        tick();
        bus_exp.push_back(8'hB1); in_read(0, 1);
        bus_exp.push_back(8'hB2); in_read(0, 1);
        bus_exp.push_back(8'hB3); in_read(0, 1);
        bus_exp.push_back(8'hC4); in_read(0, 1);
        bus_exp.push_back(8'h00); in_read(1, 1);

        // Reset in the middle of an OUT Data strobe.
        rx_push(8'hE1);
        io_input_or_output = 1'b1;
        io_data_or_address = 1'b0;
        bus_in = 8'h77;
        io_clk_s = 1'b1;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        io_clk_s = 1'b0;
        tick();
        @(negedge sys_clk);
        chk("mid_rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("mid_rst_selected", {7'b0, selected}, 8'h00);
        chk("mid_rst_flags", {6'b0, tx_overflow, rx_underflow}, 8'h00);
        chk("mid_rst_rx_ready", {7'b0, rx_ready}, 8'h01);
        tick();
        s_cycle(1, 1, 8'h0F);
        bus_exp.push_back(8'h00);
        in_read(1, 1);
        repeat (2) tick();

        chk("tx_exp_final", 8'(tx_exp.size()), 8'h00);
        chk("bus_exp_final", 8'(bus_exp.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
